// File: rtl/rv64_pkg.sv
// Shared widths, forwarding-source encoding and RAW match helper for the RV64I+Zba pipeline.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv64_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

  // A producer matches a consumer only when it is live and both name the same
  // non-zero register; x0 never carries a dependency.
  function automatic logic raw_match(input logic              valid,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return valid && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand source select: MEM result, then WB write, then register file read data.
// Latency: purely combinational. Backpressure: none, the parent stage decides when to capture.
// Build option OPERAND_FWD_EN: when undefined the register file is always selected.
module operand_fwd_mux
  import rv64_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic              mem_fwd_is_load,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic [XLEN-1:0]   val,
  output fwd_sel_e          sel
);

  // Select the youngest available producer; a load in MEM has no data yet and
  // is left to the parent's hazard logic.
  always_comb begin
    val = rf_data;
    sel = FWD_RF;
`ifdef OPERAND_FWD_EN
    if (raw_match(mem_fwd_valid && !mem_fwd_is_load, mem_fwd_rd, rs)) begin
      val = mem_fwd_data;
      sel = FWD_MEM;
    end else if (raw_match(wb_fwd_valid, wb_fwd_rd, rs)) begin
      val = wb_fwd_data;
      sel = FWD_WB;
    end
`endif
  end

`ifndef OPERAND_FWD_EN
  // Forwarding inputs are intentionally ignored in the register-file-only build.
  logic unused_fwd;
  assign unused_fwd = ^{rs, mem_fwd_valid, mem_fwd_rd, mem_fwd_is_load, mem_fwd_data,
                        wb_fwd_valid, wb_fwd_rd, wb_fwd_data};
`endif

endmodule

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: RF addressing, operand forwarding, RAW stall, ID/EX register.
// Latency: 1 cycle, an instruction accepted at edge N appears on ex_* after edge N.
// Backpressure: id_ready drops on EX stall (ex_valid && !ex_ready), RAW hazard, flush or reset.
// Build option OPERAND_FWD_EN: MEM/WB forwarding; undefined stalls on every in-flight writer.
module id_operand_stage
  import rv64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic              mem_fwd_is_load,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  fwd_sel_e        rs1_sel;
  fwd_sel_e        rs2_sel;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            hazard;
  logic            adv;
  logic            accept;

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  operand_fwd_mux u_rs1_mux (
    .rs              (id_rs1),
    .rf_data         (rf_rs1_data),
    .mem_fwd_valid   (mem_fwd_valid),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_is_load (mem_fwd_is_load),
    .mem_fwd_data    (mem_fwd_data),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
    .val             (rs1_val),
    .sel             (rs1_sel)
  );

  operand_fwd_mux u_rs2_mux (
    .rs              (id_rs2),
    .rf_data         (rf_rs2_data),
    .mem_fwd_valid   (mem_fwd_valid),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_is_load (mem_fwd_is_load),
    .mem_fwd_data    (mem_fwd_data),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
    .val             (rs2_val),
    .sel             (rs2_sel)
  );

  // Source selects are kept for debug visibility; the stage itself only needs the values.
  logic unused_sel;
  assign unused_sel = ^{rs1_sel, rs2_sel};

  // RAW hazard per used operand: with forwarding only loads without data stall,
  // without forwarding any writer still in flight stalls.
  always_comb begin
    haz_rs1 = 1'b0;
    haz_rs2 = 1'b0;
`ifdef OPERAND_FWD_EN
    haz_rs1 = id_use_rs1 &&
              (raw_match(ex_valid && ex_is_load, ex_rd, id_rs1) ||
               raw_match(mem_fwd_valid && mem_fwd_is_load, mem_fwd_rd, id_rs1));
    haz_rs2 = id_use_rs2 &&
              (raw_match(ex_valid && ex_is_load, ex_rd, id_rs2) ||
               raw_match(mem_fwd_valid && mem_fwd_is_load, mem_fwd_rd, id_rs2));
`else
    haz_rs1 = id_use_rs1 &&
              (raw_match(ex_valid, ex_rd, id_rs1) ||
               raw_match(mem_fwd_valid, mem_fwd_rd, id_rs1) ||
               raw_match(wb_fwd_valid, wb_fwd_rd, id_rs1));
    haz_rs2 = id_use_rs2 &&
              (raw_match(ex_valid, ex_rd, id_rs2) ||
               raw_match(mem_fwd_valid, mem_fwd_rd, id_rs2) ||
               raw_match(wb_fwd_valid, wb_fwd_rd, id_rs2));
`endif
  end

  assign hazard   = haz_rs1 || haz_rs2;
  assign adv      = !ex_valid || ex_ready;
  // rst_n gates id_ready so the decoder never sees a handshake while the stage is held in reset.
  assign id_ready = rst_n && adv && !hazard && !flush;
  assign accept   = adv && id_valid && !hazard;

  // ID/EX register: flush kills, accept captures, advance without accept inserts a bubble, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_pc      <= id_pc;
      ex_imm     <= id_imm;
      ex_rs1_val <= rs1_val;
      ex_rs2_val <= rs2_val;
      ex_rd      <= id_rd;
      ex_is_load <= id_is_load;
      ex_ctrl    <= id_ctrl;
    end else if (adv) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed scoreboard bench for id_operand_stage; expectations follow the OPERAND_FWD_EN build setting.
// Latency: expected ID/EX entries are pushed at acceptance and popped when EX consumes them.
// Backpressure: bench drives ex_ready low to hold the ID/EX register.
module tb_id_operand_stage;
  import rv64_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_is_load;
  logic [XLEN-1:0]   id_pc, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic              mem_fwd_valid, mem_fwd_is_load;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [XLEN-1:0]   mem_fwd_data;
  logic              wb_fwd_valid;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;

  id_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_is_load(id_is_load), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_is_load(mem_fwd_is_load),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        ld;
    logic [15:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  exp_t junk;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one decoded instruction plus the register file data the RF would return.
  task automatic present(input logic [63:0] pc, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic ld, input logic [63:0] d1, input logic [63:0] d2);
    id_valid    = 1'b1;
    id_pc       = pc;
    id_imm      = pc + 64'h8;
    id_ctrl     = pc[15:0] ^ 16'h5a5a;
    id_rs1      = r1;
    id_use_rs1  = u1;
    id_rs2      = r2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_is_load  = ld;
    rf_rs1_data = d1;
    rf_rs2_data = d2;
  endtask

  // Record what EX must eventually see for the instruction now being presented.
  task automatic push(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.pc   = id_pc;
    e.imm  = id_imm;
    e.a    = a;
    e.b    = b;
    e.rd   = id_rd;
    e.ld   = id_is_load;
    e.ctrl = id_ctrl;
    exp_q.push_back(e);
  endtask

  // Check id_ready for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic rdy);
    #1;
    chk(nm, {63'd0, id_ready}, {63'd0, rdy});
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic clr_fwd();
    mem_fwd_valid   = 1'b0;
    mem_fwd_rd      = '0;
    mem_fwd_is_load = 1'b0;
    mem_fwd_data    = '0;
    wb_fwd_valid    = 1'b0;
    wb_fwd_rd       = '0;
    wb_fwd_data     = '0;
  endtask

  // Monitor: every EX handshake pops the oldest expectation and compares the payload.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_pc=%h required=no_instruction", ex_pc);
      end else begin
        m = exp_q.pop_front();
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_rs1_val", ex_rs1_val, m.a);
        chk("ex_rs2_val", ex_rs2_val, m.b);
        chk("ex_rd_ld_ctrl", {42'd0, ex_rd, ex_is_load, ex_ctrl}, {42'd0, m.rd, m.ld, m.ctrl});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    ex_ready  = 1'b1;
    clr_fwd();
    present(64'h50, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 64'h1, 64'h2);

    // Reset state
    #2;
    chk("rst_id_ready", {63'd0, id_ready}, 64'd0);
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
    chk("rst_ex_rs1_val", ex_rs1_val, 64'd0);
    chk("rst_ex_ctrl", {48'd0, ex_ctrl}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    idle();

    // Independent ADD
    present(64'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 64'h11, 64'h22);
    #1;
    chk("rf_rs1", {59'd0, rf_rs1}, 64'd1);
    chk("rf_rs2", {59'd0, rf_rs2}, 64'd2);
    push(64'h11, 64'h22);
    cyc("add_rdy", 1'b1);
    chk("add_ex_valid", {63'd0, ex_valid}, 64'd1);
    idle();
    step();
    chk("idle_bubble", {63'd0, ex_valid}, 64'd0);

    // Source priority MEM > WB > RF
    present(64'h200, 5'd5, 1'b1, 5'd6, 1'b1, 5'd11, 1'b0, 64'h5555, 64'h66);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 64'hAAAA;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 64'hBBBB;
`ifdef OPERAND_FWD_EN
    push(64'hAAAA, 64'h66);
    cyc("prio_mem_rdy", 1'b1);
    present(64'h210, 5'd5, 1'b1, 5'd6, 1'b1, 5'd11, 1'b0, 64'h5555, 64'h66);
    mem_fwd_valid = 1'b0;
    push(64'hBBBB, 64'h66);
    cyc("prio_wb_rdy", 1'b1);
`else
    cyc("nofwd_mem_stall", 1'b0);
    chk("nofwd_mem_bubble", {63'd0, ex_valid}, 64'd0);
    mem_fwd_valid = 1'b0;
    cyc("nofwd_wb_stall", 1'b0);
    wb_fwd_valid = 1'b0;
    push(64'h5555, 64'h66);
    cyc("nofwd_rf_rdy", 1'b1);
`endif
    clr_fwd();
    idle();
    step();

    // x0 never forwards and never stalls
    present(64'h300, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 64'h0, 64'h0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 64'hDEAD;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 64'hDEAD;
    push(64'h0, 64'h0);
    cyc("x0_rdy", 1'b1);
    clr_fwd();
    idle();
    step();

    // Load in EX; unused rs2 naming the load target does not stall
    present(64'h400, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1, 64'h1000, 64'h0);
    push(64'h1000, 64'h0);
    cyc("ld_rdy", 1'b1);
    present(64'h410, 5'd1, 1'b1, 5'd7, 1'b0, 5'd13, 1'b0, 64'h11, 64'h77);
    push(64'h11, 64'h77);
    cyc("unused_rs2_rdy", 1'b1);
    idle();
    step();

    // Load-use: stall while load is in EX, then in MEM, then take WB value
    present(64'h420, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 64'h1000, 64'h0);
    push(64'h1000, 64'h0);
    cyc("ld2_rdy", 1'b1);
    present(64'h430, 5'd7, 1'b1, 5'd2, 1'b1, 5'd14, 1'b0, 64'h7777, 64'h22);
    cyc("lu_ex_stall", 1'b0);
    chk("lu_bubble1", {63'd0, ex_valid}, 64'd0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_is_load = 1'b1; mem_fwd_data = 64'hBAD;
    cyc("lu_mem_stall", 1'b0);
    chk("lu_bubble2", {63'd0, ex_valid}, 64'd0);
    clr_fwd();
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 64'h1234_5678_9ABC_DEF0;
`ifdef OPERAND_FWD_EN
    push(64'h1234_5678_9ABC_DEF0, 64'h22);
    cyc("lu_wb_rdy", 1'b1);
`else
    cyc("nofwd_lu_wb_stall", 1'b0);
    wb_fwd_valid = 1'b0;
    rf_rs1_data  = 64'h1234_5678_9ABC_DEF0;
    push(64'h1234_5678_9ABC_DEF0, 64'h22);
    cyc("nofwd_lu_rf_rdy", 1'b1);
`endif
    chk("lu_ex_valid", {63'd0, ex_valid}, 64'd1);
    clr_fwd();
    idle();
    step();

    // Backpressure: ex_ready low for 3 cycles holds EX and blocks ID
    present(64'h500, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b0, 64'h51, 64'h52);
    push(64'h51, 64'h52);
    cyc("bp_a_rdy", 1'b1);
    ex_ready = 1'b0;
    present(64'h510, 5'd3, 1'b1, 5'd4, 1'b1, 5'd16, 1'b0, 64'h53, 64'h54);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_hold_rdy", 1'b0);
      chk("bp_hold_pc", ex_pc, 64'h500);
      chk("bp_hold_valid", {63'd0, ex_valid}, 64'd1);
    end
    ex_ready = 1'b1;
    push(64'h53, 64'h54);
    cyc("bp_release_rdy", 1'b1);
    chk("bp_b_pc", ex_pc, 64'h510);
    idle();
    step();
    chk("bp_one_only", {63'd0, ex_valid}, 64'd0);

    // Flush during a held load-use stall kills EX and captures nothing
    present(64'h600, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 64'h61, 64'h0);
    push(64'h61, 64'h0);
    cyc("fl_ld_rdy", 1'b1);
    ex_ready = 1'b0;
    present(64'h610, 5'd9, 1'b1, 5'd2, 1'b1, 5'd17, 1'b0, 64'h99, 64'h22);
    flush = 1'b1;
    cyc("fl_stall_rdy", 1'b0);
    junk = exp_q.pop_front();
    chk("fl_ex_valid", {63'd0, ex_valid}, 64'd0);
    idle();
    ex_ready = 1'b1;
    step();
    chk("fl_nothing", {63'd0, ex_valid}, 64'd0);

    // Flush beats an otherwise acceptable instruction
    present(64'h620, 5'd1, 1'b1, 5'd2, 1'b1, 5'd18, 1'b0, 64'h62, 64'h63);
    flush = 1'b1;
    cyc("fl_acc_rdy", 1'b0);
    chk("fl_acc_ex_valid", {63'd0, ex_valid}, 64'd0);
    idle();
    step();

    // Dependency on a same-cycle WB write of x3
    present(64'h700, 5'd3, 1'b1, 5'd0, 1'b0, 5'd19, 1'b0, 64'h333, 64'h0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'hBBB3;
`ifdef OPERAND_FWD_EN
    push(64'hBBB3, 64'h0);
    cyc("wb3_rdy", 1'b1);
`else
    cyc("nofwd_wb3_stall", 1'b0);
    wb_fwd_valid = 1'b0;
    push(64'h333, 64'h0);
    cyc("nofwd_wb3_rf_rdy", 1'b1);
`endif
    clr_fwd();
    idle();
    step();

    // Reset asserted mid-stall: stage restarts empty, decoder re-presents
    present(64'h800, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 64'h81, 64'h0);
    push(64'h81, 64'h0);
    cyc("rs_ld_rdy", 1'b1);
    ex_ready = 1'b0;
    present(64'h810, 5'd8, 1'b1, 5'd0, 1'b0, 5'd20, 1'b0, 64'h88, 64'h0);
    cyc("rs_stall_rdy", 1'b0);
    rst_n = 1'b0;
    #1;
    junk = exp_q.pop_front();
    chk("rs_rdy_in_reset", {63'd0, id_ready}, 64'd0);
    chk("rs_ex_valid", {63'd0, ex_valid}, 64'd0);
    step();
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    push(64'h88, 64'h0);
    cyc("rs_represent_rdy", 1'b1);
    idle();
    step();
    step();
    step();

    chk("queue_empty", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
